// File: rtl/trap_pkg.sv
// trap_pkg: shared state encoding and opcode/vector constants for the trap injector.
package trap_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, OPC, LO, HI} state_t;
  localparam logic [7:0] OP_JP = 8'hC3;
  localparam logic [7:0] OP_CALL = 8'hCD;
  localparam logic [15:0] DEF_VEC_ADDR = 16'h0038;
endpackage

// File: rtl/z80_rd_strobe.sv
// z80_rd_strobe: memory-read strobe edge detector; opcode fetches exclude interrupt acknowledge.
module z80_rd_strobe (
  input  logic clk,
  input  logic rst_n,
  input  logic m1_n,
  input  logic mreq_n,
  input  logic rd_n,
  input  logic iorq_n,
  output logic rd_cyc,
  output logic rd_start,
  output logic rd_end,
  output logic fetch_start
);
  logic rd_q;
  assign rd_cyc = !mreq_n && !rd_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_q <= 1'b0;
    else rd_q <= rd_cyc;
  assign rd_start = rd_cyc && !rd_q;
  assign rd_end = !rd_cyc && rd_q;
  assign fetch_start = rd_start && !m1_n && iorq_n;
endmodule

// File: rtl/trap_injector.sv
// trap_injector: overrides three reads at an instruction boundary to feed the Z80 a JP/CALL to VEC_ADDR.
// Define TRAP_CALL_EN to inject CALL instead of JP.
module trap_injector
  import trap_pkg::*;
#(
  parameter logic [15:0] VEC_ADDR = DEF_VEC_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m1_n,
  input  logic       mreq_n,
  input  logic       rd_n,
  input  logic       iorq_n,
  input  logic       new_isr,
  input  logic       trap_req,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       mem_inhibit,
  output logic       ignore_next_isr,
  output logic       trap_ack
);
`ifdef TRAP_CALL_EN
  localparam logic [7:0] OP_INJ = OP_CALL;
`else
  localparam logic [7:0] OP_INJ = OP_JP;
`endif
  state_t state, state_d;
  logic pending, rd_cyc, rd_start, rd_end, fetch_start;
  z80_rd_strobe u_strobe (
    .clk(clk), .rst_n(rst_n), .m1_n(m1_n), .mreq_n(mreq_n), .rd_n(rd_n), .iorq_n(iorq_n),
    .rd_cyc(rd_cyc), .rd_start(rd_start), .rd_end(rd_end), .fetch_start(fetch_start)
  );
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = (pending && !fetch_start) ? ARMED : IDLE;
      ARMED:   state_d = (fetch_start && new_isr) ? OPC : ARMED;
      OPC:     state_d = rd_end ? LO : OPC;
      LO:      state_d = rd_end ? HI : LO;
      HI:      state_d = rd_end ? IDLE : HI;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pending <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && trap_req) pending <= 1'b1;
      else if (state == ARMED && state_d == OPC) pending <= 1'b0;
    end
  // Drive only while the CPU strobe is active so the bus is released with the strobe.
  assign data_oe = (state == OPC || state == LO || state == HI) && rd_cyc;
  assign mem_inhibit = data_oe;
  assign data_out = !data_oe ? 8'h00 : state == OPC ? OP_INJ : state == LO ? VEC_ADDR[7:0] : VEC_ADDR[15:8];
  assign ignore_next_isr = state == OPC;
  assign trap_ack = state == HI && rd_end;
  logic unused;
  assign unused = rd_start;
endmodule

// File: tb/tb_trap_injector.sv
// tb_trap_injector: directed bus-cycle stimulus with a scoreboard of expected read responses.
module tb_trap_injector;
`ifdef TRAP_CALL_EN
  localparam logic [7:0] EXP_OP = 8'hCD;
`else
  localparam logic [7:0] EXP_OP = 8'hC3;
`endif
  logic clk = 0, rst_n = 0, m1_n = 1, mreq_n = 1, rd_n = 1, iorq_n = 1, new_isr = 0, trap_req = 0;
  logic [7:0] data_out;
  logic data_oe, mem_inhibit, ignore_next_isr, trap_ack;
  int checks = 0, errors = 0;
  logic [10:0] exp_q[$];
  always #5 clk = ~clk;
  trap_injector dut (
    .clk(clk), .rst_n(rst_n), .m1_n(m1_n), .mreq_n(mreq_n), .rd_n(rd_n), .iorq_n(iorq_n),
    .new_isr(new_isr), .trap_req(trap_req), .data_out(data_out), .data_oe(data_oe),
    .mem_inhibit(mem_inhibit), .ignore_next_isr(ignore_next_isr), .trap_ack(trap_ack)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic expect_rd(input logic ack, input logic ign, input logic oe, input logic [7:0] b);
    exp_q.push_back({ack, ign, oe, b});
  endtask
  // One memory read of two clocks; compares the driven byte mid-read and trap_ack just after release.
  task automatic bus_read(input string tag, input logic m1, input logic iorq, input logic nisr, input logic treq);
    logic [10:0] e;
    logic [9:0] mid;
    @(negedge clk);
    m1_n = m1; iorq_n = iorq; new_isr = nisr; trap_req = treq; mreq_n = 0; rd_n = 0;
    @(posedge clk);
    @(negedge clk);
    trap_req = 0;
    mid = {ignore_next_isr, data_oe, data_out};
    chk({tag, "_inhibit"}, {31'd0, mem_inhibit}, {31'd0, data_oe});
    @(posedge clk);
    @(negedge clk);
    mreq_n = 1; rd_n = 1; m1_n = 1; iorq_n = 1; new_isr = 0;
    #1;
    if (exp_q.size() == 0) chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    else begin
      e = exp_q.pop_front();
      chk(tag, {21'd0, trap_ack, mid}, {21'd0, e});
      chk({tag, "_release"}, {31'd0, data_oe}, 32'd0);
    end
    @(posedge clk);
  endtask
  // Non-read memory cycle (refresh or write): MREQ low with RD high.
  task automatic bus_noread(input string tag);
    @(negedge clk);
    mreq_n = 0; rd_n = 1;
    @(posedge clk);
    @(negedge clk);
    chk(tag, {30'd0, data_oe, mem_inhibit}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    mreq_n = 1;
    @(posedge clk);
  endtask
  task automatic pulse_trap();
    @(negedge clk);
    trap_req = 1;
    @(negedge clk);
    trap_req = 0;
    @(negedge clk);
  endtask
  initial begin
    #1;
    chk("reset_outputs", {20'd0, data_out, data_oe, mem_inhibit, ignore_next_isr, trap_ack}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    expect_rd(0, 0, 0, 8'h00);
    bus_read("idle_fetch", 0, 1, 1, 0);
    pulse_trap();
    expect_rd(0, 1, 1, EXP_OP);
    bus_read("inj1_opc", 0, 1, 1, 0);
    bus_noread("inj1_refresh");
    expect_rd(0, 0, 1, 8'h38);
    bus_read("inj1_lo", 1, 1, 0, 0);
    expect_rd(1, 0, 1, 8'h00);
    bus_read("inj1_hi", 1, 1, 0, 0);
    bus_noread("stack_write1");
    bus_noread("stack_write2");
    expect_rd(0, 0, 0, 8'h00);
    bus_read("post_trap_fetch", 0, 1, 1, 0);
    pulse_trap();
    expect_rd(0, 0, 0, 8'h00);
    bus_read("armed_prefix", 0, 1, 0, 0);
    expect_rd(0, 1, 1, EXP_OP);
    bus_read("inj2_opc", 0, 1, 1, 0);
    expect_rd(0, 0, 1, 8'h38);
    bus_read("inj2_lo", 1, 1, 0, 0);
    bus_noread("inj2_refresh");
    bus_noread("inj2_write");
    expect_rd(1, 0, 1, 8'h00);
    bus_read("inj2_hi", 1, 1, 0, 0);
    pulse_trap();
    expect_rd(0, 0, 0, 8'h00);
    bus_read("armed_intack", 0, 0, 1, 0);
    expect_rd(0, 1, 1, EXP_OP);
    bus_read("inj3_opc", 0, 1, 1, 0);
    expect_rd(0, 0, 1, 8'h38);
    bus_read("inj3_lo", 1, 1, 0, 0);
    expect_rd(1, 0, 1, 8'h00);
    bus_read("inj3_hi", 1, 1, 0, 0);
    expect_rd(0, 0, 0, 8'h00);
    bus_read("same_edge_fetch", 0, 1, 1, 1);
    expect_rd(0, 1, 1, EXP_OP);
    bus_read("inj4_opc", 0, 1, 1, 0);
    @(negedge clk);
    mreq_n = 0; rd_n = 0;
    #1;
    chk("rst_lo_driving", {23'd0, data_oe, data_out}, {23'd0, 1'b1, 8'h38});
    rst_n = 0;
    #1;
    chk("rst_async_release", {29'd0, data_oe, mem_inhibit, ignore_next_isr}, 32'd0);
    @(negedge clk);
    mreq_n = 1; rd_n = 1;
    @(negedge clk);
    rst_n = 1;
    expect_rd(0, 0, 0, 8'h00);
    bus_read("after_rst_fetch", 0, 1, 1, 0);
    expect_rd(0, 0, 0, 8'h00);
    bus_read("after_rst_read", 1, 1, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
